dcnt60: RTL and testbench
=========================

DCNT60 -- requirements
Module: dcnt60

Interface
REQ-001 Parameter ONES_MAX, default 9, SHALL be the ones-digit reload value (ones range 0..ONES_MAX).
REQ-002 Parameter TENS_MAX, default 5, SHALL be the tens-digit reload value (tens range 0..TENS_MAX).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 BEN  in  1  SHALL be the borrow-enable pulse from a lower stage; one decrement per high cycle, honoured only in RUN.
REQ-006 DEC  in  1  SHALL be the manual decrement; one decrement per high cycle, honoured in any state.
REQ-007 CLR  in  1  SHALL be the synchronous clear to 00 and IDLE.
REQ-008 LOAD  in  1  SHALL be the preset strobe.
REQ-009 load_tens  in  3  SHALL be the tens preset value.
REQ-010 load_ones  in  4  SHALL be the ones preset value.
REQ-011 START / STOP  in  1 each  SHALL be the run and halt requests.
REQ-012 tens_place  out  3  SHALL be the registered tens digit.
REQ-013 ones_place  out  4  SHALL be the registered ones digit.
REQ-014 BO  out  1  SHALL be the combinational borrow-out to the next stage's BEN.
REQ-015 ZERO  out  1  SHALL be high iff the count is 00.
REQ-016 RUNNING  out  1  SHALL be high iff the state is RUN.
REQ-017 ALARM  out  1  SHALL be the registered one-cycle expiry pulse; the port always exists.

Function
REQ-018 Priority SHALL be rst > CLR > LOAD > decrement; the state-control priority SHALL be STOP > START.
REQ-019 The decrement event SHALL be dec_ev = DEC | (BEN & RUNNING), with LOAD and CLR low.
REQ-020 On dec_ev, ones SHALL go to ones-1, or to ONES_MAX when ones==0.
REQ-021 On dec_ev with ones==0, tens SHALL go to tens-1, or to TENS_MAX when tens==0; otherwise tens SHALL hold.
REQ-022 BO SHALL equal dec_ev & (ones==0) & (tens==0) in the same cycle (zero latency).
REQ-023 On LOAD, out-of-range preset digits SHALL clamp to ONES_MAX / TENS_MAX; the state SHALL go to IDLE.
REQ-024 The FSM SHALL have the states IDLE, RUN and EXPIRED; EXPIRED SHALL exist only under REQ-031.
REQ-025 Transitions SHALL be: IDLE-START->RUN; RUN-STOP->IDLE; EXPIRED-START->RUN; any-CLR/LOAD->IDLE.
REQ-026 START and STOP high in the same cycle SHALL result in IDLE.
REQ-027 With no event, the digits and state SHALL hold.

Reset
REQ-028 On rst: tens_place=0, ones_place=0, state IDLE, ALARM=0, ZERO=1, RUNNING=0, BO=0.
REQ-029 rst mid-RUN SHALL abandon the count in one cycle; BEN and DEC SHALL be ignored during rst.

Configuration
REQ-030 Macro DCNT60_ALARM_EN SHALL select the expiry feature.
REQ-031 With DCNT60_ALARM_EN defined:
- a BEN-driven dec_ev in RUN that yields 00 (count was 01) SHALL move the FSM to EXPIRED and pulse ALARM the next cycle.
- in EXPIRED, BEN SHALL be ignored.
- START SHALL be ignored while ZERO=1.
REQ-032 Without DCNT60_ALARM_EN:
- RUN SHALL wrap 00->(TENS_MAX,ONES_MAX) with BO.
- EXPIRED SHALL never be entered.
- ALARM SHALL be tied 0.

Structure
REQ-033 Package dcnt60_pkg SHALL hold the FSM state enum typedef and the default digit-max constants.
REQ-034 Sub-module dcnt_digit (mod-N down digit: en in, borrow out, load, clear) SHALL be instantiated twice.

Verification
REQ-035 rst; LOAD 00:10; START; 10 BEN pulses -> 09,08..00; BO=0 throughout; with ALARM_EN, ALARM=1 one cycle after 00 and state EXPIRED.
REQ-036 No ALARM_EN; count 00, RUN, BEN=1 -> BO=1 same cycle; next count 59; RUNNING=1.
REQ-037 Count 30; DEC in IDLE -> 29; BEN in IDLE -> no change.
REQ-038 LOAD tens=7, ones=12 -> count 59; LOAD with DEC in the same cycle -> 59 (LOAD wins).
REQ-039 RUN at 45; START+STOP with BEN -> IDLE, count 44; CLR with BEN -> 00, IDLE.
REQ-040 RUN at 12; rst with BEN -> 00, IDLE, ALARM=0.

Source files
------------

// File: rtl/dcnt60_pkg.sv
// Shared types and default digit limits for the two-digit down counter (minutes/seconds style).
package dcnt60_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } dcnt60_state_e;

    localparam int ONES_MAX_DEF = 9;
    localparam int TENS_MAX_DEF = 5;

endpackage

// File: rtl/dcnt60_digit.sv
// Single mod-(MAX+1) down-counting digit with clear, clamped load and borrow-out.
module dcnt_digit #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] val,
    output logic         bo
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (load) begin
            val_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            val_d = (val_q == '0) ? MAX_V : val_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val = val_q;
    // Borrow is combinational so a chain of digits ripples within one cycle.
    assign bo  = en & (val_q == '0);

endmodule

// File: rtl/dcnt60.sv
// Two-digit cascadable down counter with run/idle control.
// Optional expiry detection (EXPIRED state, ALARM pulse) enabled by macro DCNT60_ALARM_EN.
module dcnt60
    import dcnt60_pkg::*;
#(
    parameter int ONES_MAX = ONES_MAX_DEF,
    parameter int TENS_MAX = TENS_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BEN,
    input  logic       DEC,
    input  logic       CLR,
    input  logic       LOAD,
    input  logic [2:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       START,
    input  logic       STOP,
    output logic [2:0] tens_place,
    output logic [3:0] ones_place,
    output logic       BO,
    output logic       ZERO,
    output logic       RUNNING,
    output logic       ALARM
);

    dcnt60_state_e state_q, state_d;
    logic          ben_dec, dec_ev, ones_bo, tens_bo;
    logic          expire_ev, start_ok;

    assign ben_dec = BEN & (state_q == ST_RUN);
    assign dec_ev  = ~rst & ~CLR & ~LOAD & (DEC | ben_dec);

    dcnt_digit #(.W(4), .MAX(ONES_MAX)) u_ones (
        .clk      (clk),
        .rst      (rst),
        .clr      (CLR),
        .load     (LOAD),
        .load_val (load_ones),
        .en       (dec_ev),
        .val      (ones_place),
        .bo       (ones_bo)
    );

    dcnt_digit #(.W(3), .MAX(TENS_MAX)) u_tens (
        .clk      (clk),
        .rst      (rst),
        .clr      (CLR),
        .load     (LOAD),
        .load_val (load_tens),
        .en       (ones_bo),
        .val      (tens_place),
        .bo       (tens_bo)
    );

    assign BO      = tens_bo;
    assign ZERO    = (tens_place == 3'd0) && (ones_place == 4'd0);
    assign RUNNING = (state_q == ST_RUN);

`ifdef DCNT60_ALARM_EN
    // Only a borrow-driven step from 01 counts as expiry; manual DEC to 00 does not.
    assign expire_ev = ben_dec & dec_ev & (tens_place == 3'd0) & (ones_place == 4'd1);
    assign start_ok  = ~ZERO;
`else
    assign expire_ev = 1'b0;
    assign start_ok  = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        if (CLR || LOAD) begin
            state_d = ST_IDLE;
        end else if (STOP && (state_q == ST_RUN || START)) begin
            state_d = ST_IDLE;
        end else if (expire_ev) begin
            state_d = ST_EXPIRED;
        end else if (START && start_ok) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DCNT60_ALARM_EN
    logic alarm_q, alarm_d;

    assign alarm_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign ALARM = alarm_q;
`else
    assign ALARM = 1'b0;
`endif

endmodule

// File: tb/tb_dcnt60.sv
// Self-checking bench for dcnt60: directed scenarios plus randomized traffic vs a modular-arithmetic model.
module tb_dcnt60;

    localparam int OMAX = 9;
    localparam int TMAX = 5;
    localparam int MOD  = (OMAX + 1) * (TMAX + 1);
`ifdef DCNT60_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, BEN, DEC, CLR, LOAD, START, STOP;
    logic [2:0] load_tens;
    logic [3:0] load_ones;
    logic [2:0] tens_place;
    logic [3:0] ones_place;
    logic       BO, ZERO, RUNNING, ALARM;

    always #5 clk = ~clk;

    dcnt60 #(.ONES_MAX(OMAX), .TENS_MAX(TMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .BEN        (BEN),
        .DEC        (DEC),
        .CLR        (CLR),
        .LOAD       (LOAD),
        .load_tens  (load_tens),
        .load_ones  (load_ones),
        .START      (START),
        .STOP       (STOP),
        .tens_place (tens_place),
        .ones_place (ones_place),
        .BO         (BO),
        .ZERO       (ZERO),
        .RUNNING    (RUNNING),
        .ALARM      (ALARM)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: count held as a single integer 0..MOD-1; state 0=idle 1=run 2=expired.
    int m_cnt   = 0;
    int m_state = 0;
    bit m_alarm = 1'b0;
    bit exp_bo;
    logic bo_seen;

    wire [9:0] obs_vec = {tens_place, ones_place, ZERO, RUNNING, ALARM};

    function automatic logic [9:0] exp_vec();
        return {3'(m_cnt / (OMAX + 1)), 4'(m_cnt % (OMAX + 1)),
                (m_cnt == 0), (m_state == 1), m_alarm};
    endfunction

    task automatic model_step(input bit r, b, d, c, l, input int lt, lo, input bit st, sp);
        bit ben_dec, dec;
        int prev;
        if (r) begin
            m_cnt = 0; m_state = 0; m_alarm = 1'b0; exp_bo = 1'b0;
            return;
        end
        ben_dec = b && (m_state == 1);
        dec     = !c && !l && (d || ben_dec);
        prev    = m_cnt;
        exp_bo  = dec && (m_cnt == 0);
        m_alarm = 1'b0;
        if (c) begin
            m_cnt = 0; m_state = 0;
        end else if (l) begin
            m_cnt = ((lt > TMAX) ? TMAX : lt) * (OMAX + 1) + ((lo > OMAX) ? OMAX : lo);
            m_state = 0;
        end else begin
            if (dec) m_cnt = (m_cnt + MOD - 1) % MOD;
            if (sp && (m_state == 1 || st)) m_state = 0;
            else if (ALARM_EN && ben_dec && prev == 1) begin
                m_state = 2; m_alarm = 1'b1;
            end else if (st && (!ALARM_EN || prev != 0)) m_state = 1;
        end
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic cycle(input bit r, b, d, c, l, input int lt, lo, input bit st, sp);
        rst = r; BEN = b; DEC = d; CLR = c; LOAD = l;
        load_tens = 3'(lt); load_ones = 4'(lo); START = st; STOP = sp;
        #1;
        bo_seen = BO;
        model_step(r, b, d, c, l, lt, lo, st, sp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 0, 0, 0, 0, 1, 0);
        n_vec++;
        if (obs_vec !== 10'b000_0000_1_0_0) begin
            n_err++; $display("FAIL reset_state got=%b want=%b", obs_vec, 10'b000_0000_1_0_0);
        end
        n_vec++;
        if (bo_seen !== 1'b0) begin
            n_err++; $display("FAIL reset_bo got=%b want=0", bo_seen);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_countdown();
        cycle(0, 0, 0, 0, 1, 1, 0, 0, 0);
        n_vec++;
        if ({tens_place, ones_place} !== {3'd1, 4'd0}) begin
            n_err++; $display("FAIL cd_load got=%0d%0d want=10", tens_place, ones_place);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
            n_vec++;
            if (obs_vec !== exp_vec() || bo_seen !== 1'b0) begin
                n_err++;
                $display("FAIL cd_step%0d got=%b bo=%b want=%b bo=0", i, obs_vec, bo_seen, exp_vec());
            end
        end
        n_vec++;
        if ({tens_place, ones_place, RUNNING, ALARM} !== {3'd0, 4'd0, !ALARM_EN, ALARM_EN}) begin
            n_err++; $display("FAIL cd_end got=%0d%0d run=%b alarm=%b", tens_place, ones_place, RUNNING, ALARM);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (ALARM !== 1'b0) begin
            n_err++; $display("FAIL cd_alarm_pulse got=%b want=0", ALARM);
        end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (obs_vec !== exp_vec() || bo_seen !== exp_bo) begin
            n_err++; $display("FAIL wrap got=%b bo=%b want=%b bo=%b", obs_vec, bo_seen, exp_vec(), exp_bo);
        end
`ifndef DCNT60_ALARM_EN
        n_vec++;
        if ({bo_seen, tens_place, ones_place, RUNNING} !== {1'b1, 3'd5, 4'd9, 1'b1}) begin
            n_err++; $display("FAIL wrap_59 got=%b %0d%0d run=%b want=1 59 run=1", bo_seen, tens_place, ones_place, RUNNING);
        end
`endif
    endtask

    task automatic test_idle_dec();
        cycle(0, 0, 0, 0, 1, 3, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if ({tens_place, ones_place, RUNNING} !== {3'd2, 4'd9, 1'b0}) begin
            n_err++; $display("FAIL idle_dec got=%0d%0d want=29", tens_place, ones_place);
        end
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if ({tens_place, ones_place} !== {3'd2, 4'd9}) begin
            n_err++; $display("FAIL idle_ben got=%0d%0d want=29", tens_place, ones_place);
        end
    endtask

    task automatic test_load_clamp();
        cycle(0, 0, 0, 0, 1, 7, 12, 0, 0);
        n_vec++;
        if ({tens_place, ones_place} !== {3'd5, 4'd9}) begin
            n_err++; $display("FAIL load_clamp got=%0d%0d want=59", tens_place, ones_place);
        end
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1, 7, 12, 0, 0);
        n_vec++;
        if ({tens_place, ones_place} !== {3'd5, 4'd9}) begin
            n_err++; $display("FAIL load_vs_dec got=%0d%0d want=59", tens_place, ones_place);
        end
    endtask

    task automatic test_start_stop();
        cycle(0, 0, 0, 0, 1, 4, 5, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        n_vec++;
        if (RUNNING !== 1'b1) begin
            n_err++; $display("FAIL start got=%b want=1", RUNNING);
        end
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 1);
        n_vec++;
        if ({tens_place, ones_place, RUNNING} !== {3'd4, 4'd4, 1'b0}) begin
            n_err++; $display("FAIL start_stop got=%0d%0d run=%b want=44 run=0", tens_place, ones_place, RUNNING);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
        n_vec++;
        if ({tens_place, ones_place, RUNNING, ZERO} !== {3'd0, 4'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL clr_ben got=%0d%0d run=%b want=00 run=0", tens_place, ones_place, RUNNING);
        end
    endtask

    task automatic test_rst_mid_run();
        cycle(0, 0, 0, 0, 1, 1, 2, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if ({obs_vec, bo_seen} !== {10'b000_0000_1_0_0, 1'b0}) begin
            n_err++; $display("FAIL rst_mid_run got=%b bo=%b want=%b bo=0", obs_vec, bo_seen, 10'b000_0000_1_0_0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 3), $urandom_range(0, 7), $urandom_range(0, 15),
                  ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 5));
            n_vec++;
            if (obs_vec !== exp_vec() || bo_seen !== exp_bo) begin
                n_err++;
                $display("FAIL rand%0d got=%b bo=%b want=%b bo=%b", i, obs_vec, bo_seen, exp_vec(), exp_bo);
            end
        end
    endtask

    initial begin
        rst = 1'b1; BEN = 1'b0; DEC = 1'b0; CLR = 1'b0; LOAD = 1'b0;
        START = 1'b0; STOP = 1'b0; load_tens = '0; load_ones = '0;
        @(negedge clk);
        test_reset();
        test_countdown();
        test_wrap();
        test_idle_dec();
        test_load_clamp();
        test_start_stop();
        test_rst_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
